// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC holder, instruction fetch handshake and next-PC selection
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   imem_req/addr         fetch request and word address (= pc)
//   imem_ready/rdata      memory data valid and instruction word
//   stall                 holds the EXEC state
//   jump/jumpReg          decoder jump controls (J/JAL, JR)
//   branchatall/bne/zero  conditional branch controls and ALU zero flag
//   jr_addr               JR target (register rs value)
//   instr_valid           instr fields valid (EXEC)
//   op/funct/rs/rt/rd     decoded instruction fields
//   imm16/target          immediate and jump target fields
//   pc/pc_plus4           current instruction address and link value
//   retired               completed instruction count
//   fetch_timeout         sticky fetch-wait timeout flag

module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        jump,
  input  logic        jumpReg,
  input  logic        branchatall,
  input  logic        bne,
  input  logic        zero,
  input  logic [31:0] jr_addr,
  output logic        instr_valid,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [25:0] target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retired,
  output logic        fetch_timeout
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;

  localparam int            CW       = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

  logic [1:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   retired_q, retired_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout_q, timeout_d;

  logic [31:0]   pc_plus4_w;
  logic [31:0]   branch_off;
  logic          branch_taken;
  logic [31:0]   next_pc;

  // Outputs decode directly from state so reset drops the request at once.
  assign imem_req      = (state_q == ST_FETCH);
  assign imem_addr     = pc_q;
  assign instr_valid   = (state_q == ST_EXEC);

  assign op            = instr_q[31:26];
  assign rs            = instr_q[25:21];
  assign rt            = instr_q[20:16];
  assign rd            = instr_q[15:11];
  assign funct         = instr_q[5:0];
  assign imm16         = instr_q[15:0];
  assign target        = instr_q[25:0];

  assign pc            = pc_q;
  assign pc_plus4      = pc_plus4_w;
  assign retired       = retired_q;
  assign fetch_timeout = timeout_q;

  assign pc_plus4_w    = pc_q + 32'd4;
  // Sign-extended word offset; modulo-2^32 add handles negative offsets.
  assign branch_off    = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign branch_taken  = branchatall && (zero ^ bne);

  always_comb begin
    next_pc = pc_plus4_w;
    if (jumpReg) begin
      next_pc = {jr_addr[31:2], 2'b00};
    end else if (jump) begin
      next_pc = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus4_w + branch_off;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    retired_d  = retired_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = ST_EXEC;
        end else begin
          if (wait_cnt_q != WAIT_LIM) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
          end
          if (wait_cnt_d == WAIT_LIM) begin
            timeout_d = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        // Controls only matter on the edge that leaves EXEC.
        if (!stall) begin
          pc_d       = next_pc;
          retired_d  = retired_q + 32'd1;
          wait_cnt_d = '0;
          state_d    = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      retired_q  <= 32'd0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      retired_q  <= retired_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule
